// File: rtl/mig_seq_eval.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mig_seq_eval: sequential evaluator for a programmable majority-inverter    |
// | graph; one MAJ node per cycle over latched primary inputs.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mig_seq_eval #(
  parameter int N_IN      = 7,
  parameter int MAX_NODES = 16,
  localparam int SEL_W    = $clog2(N_IN + MAX_NODES + 1),
  localparam int NODE_W   = 3 * (SEL_W + 1),
  localparam int AW       = $clog2(MAX_NODES),
  localparam int LW       = $clog2(MAX_NODES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [NODE_W-1:0] cfg_data,
  input  logic [LW-1:0]     cfg_len,
  input  logic              start,
  input  logic [N_IN-1:0]   x,
  output logic              busy,
  output logic              done,
  output logic              out,
  output logic              err
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_eval = 2'd1;
  localparam logic [1:0] c_st_fail = 2'd2;

  logic [1:0]           r_state;
  logic [NODE_W-1:0]    r_prog [MAX_NODES];
  logic [MAX_NODES-1:0] r_w;
  logic [AW-1:0]        r_k;
  logic [LW-1:0]        r_len;
  logic [N_IN-1:0]      r_x;

  logic [NODE_W-1:0]    w_word;
  logic [1:0]           w_opa, w_opb, w_opc;
  logic                 w_bad, w_maj, w_last, w_len_ok;

  // Returns {illegal, value}; node operands are legal only when already computed (j < k).
  function automatic logic [1:0] operand(input logic [SEL_W-1:0] sel, input logic inv,
                                         input logic [N_IN-1:0] xv,
                                         input logic [MAX_NODES-1:0] wv,
                                         input logic [AW-1:0] k);
    logic bad;
    logic val;
    bad = 1'b1;
    val = 1'b0;
    if (sel == '0) bad = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (int'(sel) == i + 1) begin
        bad = 1'b0;
        val = xv[i];
      end
    end
    for (int j = 0; j < MAX_NODES; j++) begin
      if (int'(sel) == N_IN + 1 + j && j < int'(k)) begin
        bad = 1'b0;
        val = wv[j];
      end
    end
    return {bad, val ^ inv};
  endfunction

  always_comb begin
    w_word   = r_prog[r_k];
    w_opa    = operand(w_word[SEL_W-1:0], w_word[SEL_W], r_x, r_w, r_k);
    w_opb    = operand(w_word[(SEL_W+1) +: SEL_W], w_word[2*SEL_W+1], r_x, r_w, r_k);
    w_opc    = operand(w_word[2*(SEL_W+1) +: SEL_W], w_word[3*SEL_W+2], r_x, r_w, r_k);
    w_bad    = w_opa[1] | w_opb[1] | w_opc[1];
    w_maj    = (w_opa[0] & w_opb[0]) | (w_opa[0] & w_opc[0]) | (w_opb[0] & w_opc[0]);
    w_last   = ({1'b0, r_k} == r_len - LW'(1));
    w_len_ok = (cfg_len != '0) && (cfg_len <= LW'(MAX_NODES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      busy    <= 1'b0;
      done    <= 1'b0;
      out     <= 1'b0;
      err     <= 1'b0;
      r_k     <= '0;
      r_len   <= '0;
      r_x     <= '0;
      r_w     <= '0;
      for (int i = 0; i < MAX_NODES; i++) r_prog[i] <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (cfg_we && 32'(cfg_addr) < MAX_NODES) r_prog[cfg_addr] <= cfg_data;
          if (start) begin
            r_k <= '0;
            if (w_len_ok) begin
              r_x     <= x;
              r_len   <= cfg_len;
              err     <= 1'b0;
              busy    <= 1'b1;
              r_state <= c_st_eval;
            end else begin
              r_state <= c_st_fail;
            end
          end
        end
        c_st_eval: begin
          if (w_bad) begin
            out     <= 1'b0;
            err     <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= c_st_idle;
          end else begin
            r_w[r_k] <= w_maj;
            if (w_last) begin
              out     <= w_maj;
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= c_st_idle;
            end else begin
              r_k <= r_k + AW'(1);
            end
          end
        end
        c_st_fail: begin
          // r_k doubles as the dwell counter so the reject reports two cycles after start
          if (r_k == '0) begin
            r_k <= AW'(1);
          end else begin
            r_k     <= '0;
            out     <= 1'b0;
            err     <= 1'b1;
            done    <= 1'b1;
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mig_seq_eval.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mig_seq_eval: directed, table-driven bench for mig_seq_eval.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mig_seq_eval;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [17:0] cfg_data;
  logic [4:0]  cfg_len;
  logic        start;
  logic [6:0]  x;
  logic        busy, done, out, err;

  int n_vec = 0;
  int n_err = 0;

  mig_seq_eval #(.N_IN(7), .MAX_NODES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .start(start), .x(x), .busy(busy), .done(done), .out(out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] x;
    logic       exp_out;
  } vec_t;

  vec_t tbl [3];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] node(input bit ia, input int sa, input bit ib, input int sb,
                                       input bit ic, input int sc);
    return {ic, 5'(sc), ib, 5'(sb), ia, 5'(sa)};
  endfunction

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic chain_model(input logic [6:0] v);
    logic w0, w1, w2, w3;
    w0 = maj(v[2], v[3], v[4]);
    w1 = maj(v[5], v[6], w0);
    w2 = maj(v[0], v[1], w1);
    w3 = maj(v[2], v[3], w2);
    return maj(v[4], w2, w3);
  endfunction

  function automatic logic long_model(input logic [6:0] v);
    logic [15:0] m;
    m[0] = maj(v[0], v[1], v[2]);
    m[1] = maj(v[3], ~v[4], v[5]);
    m[2] = maj(v[6], m[0], ~m[1]);
    for (int k = 3; k < 16; k++) m[k] = maj(m[k-1], ~m[k-2], v[k % 7] ^ k[0]);
    return m[15];
  endfunction

  function automatic logic [17:0] long_node(input int k);
    if (k == 0) return node(0, 1, 0, 2, 0, 3);
    if (k == 1) return node(0, 4, 1, 5, 0, 6);
    if (k == 2) return node(0, 7, 0, 8, 1, 9);
    return node(0, 8 + k - 1, 1, 8 + k - 2, k[0], (k % 7) + 1);
  endfunction

  task automatic write_node(input int a, input logic [17:0] d);
    cfg_we   = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = d;
    @(posedge clk); #1;
    cfg_we   = 1'b0;
  endtask

  // Inputs are scrambled right after the start edge to show they are latched.
  task automatic start_eval(input int len, input logic [6:0] xv);
    start   = 1'b1;
    cfg_len = 5'(len);
    x       = xv;
    @(posedge clk); #1;
    start   = 1'b0;
    cfg_we  = 1'b0;
    x       = ~xv;
  endtask

  task automatic wait_done(output int lat, output logic o, output logic e, output bit bs);
    lat = -1;
    o   = 1'bx;
    e   = 1'bx;
    bs  = busy;
    for (int c = 1; c <= 40; c++) begin
      if (lat < 0) begin
        @(posedge clk); #1;
        if (done) begin
          lat = c;
          o   = out;
          e   = err;
        end else begin
          bs = bs | busy;
        end
      end
    end
  endtask

  task automatic run_eval(input int len, input logic [6:0] xv, output int lat,
                          output logic o, output logic e, output bit bs);
    start_eval(len, xv);
    wait_done(lat, o, e, bs);
  endtask

  initial begin
    int   lat;
    logic o, e;
    bit   bs;
    bit   seen;
    logic [6:0] lx [8];

    tbl[0] = '{x: 7'h00, exp_out: 1'b0};
    tbl[1] = '{x: 7'h7f, exp_out: 1'b1};
    tbl[2] = '{x: 7'h03, exp_out: 1'b0};
    lx = '{7'h00, 7'h7f, 7'h55, 7'h2a, 7'h13, 7'h6c, 7'h01, 7'h40};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_len = '0; start = 1'b0; x = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_out", out, 0);
    chk("reset_err", err, 0);
    rst_n = 1'b1;

    write_node(0, node(0, 3, 0, 4, 0, 5));
    write_node(1, node(0, 6, 0, 7, 0, 8));
    write_node(2, node(0, 1, 0, 2, 0, 9));
    write_node(3, node(0, 3, 0, 4, 0, 10));
    write_node(4, node(0, 5, 0, 10, 0, 11));

    for (int i = 0; i < 3; i++) begin
      run_eval(5, tbl[i].x, lat, o, e, bs);
      chk($sformatf("chain_out x=%h", tbl[i].x), o, tbl[i].exp_out);
      chk($sformatf("chain_lat x=%h", tbl[i].x), lat, 5);
      chk($sformatf("chain_err x=%h", tbl[i].x), e, 0);
    end
    for (int v = 0; v < 128; v++) begin
      run_eval(5, 7'(v), lat, o, e, bs);
      chk($sformatf("sweep_out x=%h", v), o, chain_model(7'(v)));
      chk($sformatf("sweep_lat x=%h", v), lat, 5);
    end

    // cfg_we and start during busy must both be dropped
    start_eval(5, 7'h7f);
    cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = '0;
    start = 1'b1; cfg_len = 5'd1;
    @(posedge clk); #1;
    cfg_we = 1'b0; start = 1'b0;
    wait_done(lat, o, e, bs);
    chk("busy_ign_lat", lat + 1, 5);
    chk("busy_ign_out", o, 1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | done | busy;
    end
    chk("busy_ign_no_restart", seen, 0);
    run_eval(5, 7'h7f, lat, o, e, bs);
    chk("busy_ign_prog_kept", o, 1);

    run_eval(0, 7'h7f, lat, o, e, bs);
    chk("len0_lat", lat, 2);
    chk("len0_err", e, 1);
    chk("len0_out", o, 0);
    chk("len0_busy", bs, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_held", err, 1);
    run_eval(17, 7'h7f, lat, o, e, bs);
    chk("len17_lat", lat, 2);
    chk("len17_err", e, 1);
    chk("len17_out", o, 0);
    chk("len17_busy", bs, 0);

    write_node(0, node(1, 1, 0, 0, 1, 0));
    run_eval(1, 7'h01, lat, o, e, bs);
    chk("inv_out_x1", o, 0);
    chk("inv_err", e, 0);
    chk("inv_lat", lat, 1);
    run_eval(1, 7'h00, lat, o, e, bs);
    chk("inv_out_x0", o, 1);

    write_node(0, node(0, 9, 0, 0, 0, 0));
    run_eval(2, 7'h7f, lat, o, e, bs);
    chk("fwd_lat", lat, 1);
    chk("fwd_err", e, 1);
    chk("fwd_out", o, 0);
    write_node(0, node(0, 30, 0, 1, 0, 1));
    run_eval(1, 7'h7f, lat, o, e, bs);
    chk("illsel_lat", lat, 1);
    chk("illsel_err", e, 1);

    write_node(0, node(0, 3, 0, 4, 0, 5));
    run_eval(5, 7'h7f, lat, o, e, bs);
    chk("prereset_out", o, 1);
    start_eval(5, 7'h7f);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_out", out, 0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | done;
    end
    chk("rst_mid_no_done", seen, 0);
    rst_n = 1'b1;
    run_eval(5, 7'h7f, lat, o, e, bs);
    chk("postrst_lat", lat, 5);
    chk("postrst_mem_zero", o, 0);
    chk("postrst_err", e, 0);

    for (int k = 0; k < 15; k++) write_node(k, long_node(k));
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        cfg_we = 1'b1; cfg_addr = 4'd15; cfg_data = long_node(15);
      end
      run_eval(16, lx[i], lat, o, e, bs);
      chk($sformatf("long_out x=%h", lx[i]), o, long_model(lx[i]));
      chk($sformatf("long_lat x=%h", lx[i]), lat, 16);
      chk($sformatf("long_err x=%h", lx[i]), e, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
